main_memory_arbiter: RTL and testbench
======================================

// Module: main_memory_arbiter
// PURPOSE
//  Shares the single main-memory port between the instruction-cache and data-cache miss interfaces.
//  Round-robin arbitration selects one requester. The block emulates main-memory latency with an
//  internal counter, then issues one access to the memory array. It returns the line (read) or an
//  acknowledge (write) to the winner. Sits between fetch/memory stages and main memory.
// PARAMETERS
//  ADDR_WIDTH   32   byte address width (= PC_WIDTH)
//  LINE_WIDTH   128  cache line width in bits; OFFSET = $clog2(LINE_WIDTH/8)
//  MEM_LATENCY  10   wait cycles before the array access; legal range >= 1
// PORTS
//  clock             in   1                  core clock
//  reset             in   1                  synchronous, active-high
//  icache_req_valid  in   1                  I$ miss request; held until icache_rsp_valid
//  icache_req_addr   in   ADDR_WIDTH         I$ miss byte address
//  icache_rsp_valid  out  1                  one-cycle pulse: line returned
//  icache_rsp_data   out  LINE_WIDTH         returned line
//  dcache_req_valid  in   1                  D$ miss/evict request; held until dcache_rsp_valid
//  dcache_req_addr   in   ADDR_WIDTH         D$ byte address
//  dcache_req_we     in   1                  1 = write line back, 0 = read line
//  dcache_req_data   in   LINE_WIDTH         write-back line
//  dcache_rsp_valid  out  1                  one-cycle pulse: read data or write ack
//  dcache_rsp_data   out  LINE_WIDTH         returned line (reads); write ack returns all zeros
//  mem_en            out  1                  array access strobe, one cycle
//  mem_we            out  1                  array write enable, qualified by mem_en
//  mem_addr          out  ADDR_WIDTH-OFFSET  line index = latched addr[ADDR_WIDTH-1:OFFSET]
//  mem_wdata         out  LINE_WIDTH         write line
//  mem_rdata         in   LINE_WIDTH         array read data, valid the cycle after mem_en
//  busy              out  1                  1 whenever state != IDLE
// BEHAVIOUR
//  Reset:
//   - state=IDLE, cnt=0, last_grant=DCACHE (so the I$ wins the first tie).
//   - All outputs 0, including data buses and busy.
//  FSM:
//   - IDLE -> WAIT when any req_valid=1.
//     - Grant: only one requesting -> that one. Both -> the one != last_grant.
//     - On grant: latch id, addr, we, wdata; update last_grant; cnt <= 0.
//     - An I$ grant always latches we=0.
//   - WAIT: cnt increments each cycle. When cnt == MEM_LATENCY-1: assert mem_en (plus mem_we, mem_addr,
//     mem_wdata from latches) for this cycle only, then go to READ.
//   - READ: capture mem_rdata into the rsp data reg (zeros if latched we=1), then go to DONE.
//   - DONE: assert the winner's rsp_valid for exactly one cycle with its rsp_data, then go to IDLE.
//     No grant is made in DONE, so a requester that still holds req_valid in its rsp cycle is never
//     re-granted.
//  Outputs and timing:
//   - Non-selected rsp_valid=0; its rsp_data=0.
//   - mem_* outputs are 0 whenever mem_en=0.
//   - Request sampled in IDLE at cycle T: mem_en at T+MEM_LATENCY, rsp_valid at T+MEM_LATENCY+2.
//   - Back-to-back requests: next grant is at the earliest in the IDLE cycle after DONE.
//  Counter:
//   - cnt width $clog2(MEM_LATENCY+1); it never wraps.
//   - MEM_LATENCY=1 gives mem_en in the first WAIT cycle.
//  Boundary cases:
//   - req_valid dropped mid-transaction: ignored. The access completes and rsp still pulses.
//   - Latched addr/we/wdata are immune to input changes after grant.
//   - Reset asserted in any state: IDLE on the next edge. Any pending mem_en or rsp_valid is
//     suppressed; no partial response is issued.
// TESTING (MEM_LATENCY=4)
//  1. I$ read addr 0x100 at cycle 0 -> mem_en=1, mem_we=0, mem_addr=0x10 at cycle 4;
//     mem_rdata=0xA5.. at cycle 5; icache_rsp_valid=1 with 0xA5.. at cycle 6; busy 1 for cycles 1-6.
//  2. I$ and D$ both request at cycle 0 after reset -> I$ granted first; D$ mem_en at cycle 11;
//     dcache_rsp_valid at 13.
//  3. D$ write addr 0x2F0, data 0xDEAD.. -> mem_en=1, mem_we=1, mem_addr=0x2F, mem_wdata=0xDEAD..
//     at cycle 4; dcache_rsp_valid at 6 with data 0.
//  4. Both requesters held high continuously -> grants alternate I$, D$, I$, D$;
//     every rsp_valid is exactly one cycle; never two rsp pulses in the same cycle.
//  5. Reset pulsed at cycle 3 of an I$ read -> no mem_en, no rsp_valid;
//     all outputs 0 the cycle after reset; a new request is then served from IDLE.
//  6. Change icache_req_addr to 0x400 at cycle 2 of a read of 0x100 -> mem_addr still 0x10.

Source files
------------

// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter that shares the single main-memory port between the I$ and D$ miss paths.
// A latency counter emulates memory delay, then one array access is made and the winner answered.
module main_memory_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int MEM_LATENCY = 10
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic                                              icache_req_valid,
  input  logic [ADDR_WIDTH-1:0]                             icache_req_addr,
  output logic                                              icache_rsp_valid,
  output logic [LINE_WIDTH-1:0]                             icache_rsp_data,
  input  logic                                              dcache_req_valid,
  input  logic [ADDR_WIDTH-1:0]                             dcache_req_addr,
  input  logic                                              dcache_req_we,
  input  logic [LINE_WIDTH-1:0]                             dcache_req_data,
  output logic                                              dcache_rsp_valid,
  output logic [LINE_WIDTH-1:0]                             dcache_rsp_data,
  output logic                                              mem_en,
  output logic                                              mem_we,
  output logic [ADDR_WIDTH-$clog2(LINE_WIDTH/8)-1:0]        mem_addr,
  output logic [LINE_WIDTH-1:0]                             mem_wdata,
  input  logic [LINE_WIDTH-1:0]                             mem_rdata,
  output logic                                              busy
);

  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W  = ADDR_WIDTH - OFFSET;
  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_id_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  req_id_t           last_grant;
  req_id_t           owner;
  req_id_t           grant_id;
  logic              grant_fire;
  logic              mem_fire;
  logic [IDX_W-1:0]  addr_q;
  logic              we_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] rsp_data_q;

  // The memory is line-granular, so byte-offset bits of the request addresses carry no meaning here.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{icache_req_addr[OFFSET-1:0], dcache_req_addr[OFFSET-1:0]};

  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a missing branch would infer a latch.
    state_next       = state;
    grant_fire       = 1'b0;
    grant_id         = REQ_ICACHE;
    mem_fire         = (state == S_WAIT) && (cnt == CNT_LAST);
    mem_en           = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    icache_rsp_valid = 1'b0;
    icache_rsp_data  = '0;
    dcache_rsp_valid = 1'b0;
    dcache_rsp_data  = '0;
    busy             = (state != S_IDLE);

    // On a tie the requester that did not win last time is chosen.
    if (icache_req_valid && dcache_req_valid) begin
      grant_id = (last_grant == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
    end else if (dcache_req_valid) begin
      grant_id = REQ_DCACHE;
    end

    case (state)
      S_IDLE: begin
        if (icache_req_valid || dcache_req_valid) begin
          grant_fire = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_fire) state_next = S_READ;
      end
      S_READ:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (mem_fire) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end

    if (state == S_DONE) begin
      if (owner == REQ_ICACHE) begin
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = rsp_data_q;
      end else begin
        dcache_rsp_valid = 1'b1;
        dcache_rsp_data  = rsp_data_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: datapath registers are cleared too, so nothing stale can reach an output after reset.
    if (reset) begin
      cnt        <= '0;
      last_grant <= REQ_DCACHE;
      owner      <= REQ_ICACHE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      if (grant_fire) begin
        owner      <= grant_id;
        last_grant <= grant_id;
        cnt        <= '0;
        if (grant_id == REQ_DCACHE) begin
          addr_q  <= dcache_req_addr[ADDR_WIDTH-1:OFFSET];
          we_q    <= dcache_req_we;
          wdata_q <= dcache_req_data;
        end else begin
          addr_q  <= icache_req_addr[ADDR_WIDTH-1:OFFSET];
          we_q    <= 1'b0;
          wdata_q <= '0;
        end
      end else if ((state == S_WAIT) && !mem_fire) begin
        cnt <= cnt + CNT_W'(1);
      end

      // A write acknowledge carries an all-zero line.
      if (state == S_READ) begin
        rsp_data_q <= we_q ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Scoreboard bench for main_memory_arbiter at MEM_LATENCY=4: stimulus pushes expected memory
// accesses and responses; a negedge monitor pops and compares them when the DUT presents them.
module tb_main_memory_arbiter;

  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int LAT = 4;
  localparam int IW  = AW - 4;

  localparam logic [LW-1:0] LINE_A5   = {16{8'hA5}};
  localparam logic [LW-1:0] LINE_3C   = {16{8'h3C}};
  localparam logic [LW-1:0] LINE_96   = {16{8'h96}};
  localparam logic [LW-1:0] LINE_EE   = {16{8'hEE}};
  localparam logic [LW-1:0] LINE_DEAD = {8{16'hDEAD}};
  localparam logic [LW-1:0] LINE_12   = {16{8'h12}};
  localparam logic [LW-1:0] JUNK      = {16{8'h77}};

  typedef struct {
    bit          is_d;
    int          cyc;
    logic [LW-1:0] data;
  } rsp_t;

  typedef struct {
    int          cyc;
    bit          we;
    logic [IW-1:0] addr;
    logic [LW-1:0] wdata;
  } mem_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          icache_req_valid = 1'b0;
  logic [AW-1:0] icache_req_addr = '0;
  logic          icache_rsp_valid;
  logic [LW-1:0] icache_rsp_data;
  logic          dcache_req_valid = 1'b0;
  logic [AW-1:0] dcache_req_addr = '0;
  logic          dcache_req_we = 1'b0;
  logic [LW-1:0] dcache_req_data = '0;
  logic          dcache_rsp_valid;
  logic [LW-1:0] dcache_rsp_data;
  logic          mem_en;
  logic          mem_we;
  logic [IW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  rsp_t rsp_q[$];
  mem_t mem_q[$];
  logic [LW-1:0] mem_model [logic [IW-1:0]];

  main_memory_arbiter #(
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW),
    .MEM_LATENCY(LAT)
  ) dut (
    .clock           (clk),
    .reset           (reset),
    .icache_req_valid(icache_req_valid),
    .icache_req_addr (icache_req_addr),
    .icache_rsp_valid(icache_rsp_valid),
    .icache_rsp_data (icache_rsp_data),
    .dcache_req_valid(dcache_req_valid),
    .dcache_req_addr (dcache_req_addr),
    .dcache_req_we   (dcache_req_we),
    .dcache_req_data (dcache_req_data),
    .dcache_rsp_valid(dcache_rsp_valid),
    .dcache_rsp_data (dcache_rsp_data),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_cmp++;
    n_err++;
    $display("FAIL %s at cycle %0d: %s", name, cyc, msg);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Array model: read data is presented only in the cycle after mem_en.
  initial begin
    mem_model[28'h10] = LINE_A5;
    mem_model[28'h33] = LINE_3C;
    mem_model[28'h40] = LINE_96;
    mem_rdata = JUNK;
    forever begin
      logic [IW-1:0] a;
      logic          w;
      logic [LW-1:0] d;
      @(negedge clk);
      if (mem_en === 1'b1) begin
        a = mem_addr;
        w = mem_we;
        d = mem_wdata;
        @(posedge clk);
        #1;
        if (w) begin
          mem_model[a] = d;
          mem_rdata = ~JUNK;
        end else begin
          mem_rdata = mem_model.exists(a) ? mem_model[a] : LINE_EE;
        end
        @(posedge clk);
        #1;
        mem_rdata = JUNK;
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard pops on mem_en and rsp pulses.
  initial begin
    forever begin
      @(negedge clk);
      check("two_rsp_same_cycle", icache_rsp_valid & dcache_rsp_valid, 0);
      if (!mem_en) check("mem_bus_idle_zero", {mem_we, mem_addr, mem_wdata}, 0);
      if (!icache_rsp_valid) check("irsp_data_idle_zero", icache_rsp_data, 0);
      if (!dcache_rsp_valid) check("drsp_data_idle_zero", dcache_rsp_data, 0);
      if (mem_en) begin
        if (mem_q.size() == 0) begin
          fail("mem_unexpected", $sformatf("mem_en=1 addr=%0h, required no access", mem_addr));
        end else begin
          mem_t m;
          m = mem_q.pop_front();
          check("mem_cycle", cyc, m.cyc);
          check("mem_we", mem_we, m.we);
          check("mem_addr", mem_addr, m.addr);
          if (m.we) check("mem_wdata", mem_wdata, m.wdata);
        end
      end
      for (int p = 0; p < 2; p++) begin
        logic          v;
        logic [LW-1:0] d;
        v = (p == 0) ? icache_rsp_valid : dcache_rsp_valid;
        d = (p == 0) ? icache_rsp_data : dcache_rsp_data;
        if (v) begin
          if (rsp_q.size() == 0) begin
            fail("rsp_unexpected", $sformatf("rsp_valid on port %0d, required none", p));
          end else begin
            rsp_t r;
            r = rsp_q.pop_front();
            check("rsp_port", p, r.is_d);
            check("rsp_cycle", cyc, r.cyc);
            check("rsp_data", d, r.data);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem"}, {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    check({tag, "_irsp"}, {icache_rsp_valid, icache_rsp_data}, 0);
    check({tag, "_drsp"}, {dcache_rsp_valid, dcache_rsp_data}, 0);
  endtask

  // One request from idle. mode 1: disturb inputs after grant; mode 2: drop req_valid after grant.
  task automatic single(input bit is_d, input logic [AW-1:0] addr, input bit we,
                        input logic [LW-1:0] wdata, input logic [LW-1:0] exp_data, input int mode);
    int   t0;
    mem_t m;
    rsp_t r;
    t0 = cyc;
    m.cyc = t0 + LAT;  m.we = we;  m.addr = addr[AW-1:4];  m.wdata = wdata;
    mem_q.push_back(m);
    r.is_d = is_d;  r.cyc = t0 + LAT + 2;  r.data = exp_data;
    rsp_q.push_back(r);
    if (is_d) begin
      dcache_req_valid = 1'b1;
      dcache_req_addr  = addr;
      dcache_req_we    = we;
      dcache_req_data  = wdata;
    end else begin
      icache_req_valid = 1'b1;
      icache_req_addr  = addr;
    end
    for (int k = 0; k <= LAT + 2; k++) begin
      if (k > 0) tick(1);
      if (k == 2 && mode == 1) begin
        icache_req_addr = 32'h400;
        dcache_req_addr = 32'h600;
        dcache_req_we   = ~we;
        dcache_req_data = ~wdata;
      end
      if (k == 2 && mode == 2) begin
        icache_req_valid = 1'b0;
        dcache_req_valid = 1'b0;
      end
      @(negedge clk);
      check("busy", busy, k >= 1);
    end
    tick(1);
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
    dcache_req_we    = 1'b0;
  endtask

  // Both requesters held for four transactions; grants must alternate I$, D$, I$, D$.
  task automatic both_held();
    int t0;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      mem_t m;
      rsp_t r;
      int   g;
      g = t0 + 7 * i;
      m.cyc = g + LAT;  m.we = 1'b0;  m.addr = (i % 2 == 1) ? 28'h33 : 28'h10;  m.wdata = '0;
      mem_q.push_back(m);
      r.is_d = (i % 2 == 1);  r.cyc = g + LAT + 2;  r.data = (i % 2 == 1) ? LINE_3C : LINE_A5;
      rsp_q.push_back(r);
    end
    icache_req_addr  = 32'h100;
    dcache_req_addr  = 32'h330;
    dcache_req_we    = 1'b0;
    icache_req_valid = 1'b1;
    dcache_req_valid = 1'b1;
    tick(28);
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
  endtask

  initial begin
    int t0;
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    check_all_zero("in_reset");
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");
    tick(1);

    single(1'b0, 32'h100, 1'b0, '0, LINE_A5, 0);
    single(1'b1, 32'h2F0, 1'b1, LINE_DEAD, '0, 0);
    single(1'b1, 32'h2F0, 1'b0, '0, LINE_DEAD, 0);
    single(1'b1, 32'h500, 1'b1, LINE_12, '0, 1);
    single(1'b1, 32'h500, 1'b0, '0, LINE_12, 0);
    single(1'b0, 32'h100, 1'b0, '0, LINE_A5, 1);
    single(1'b0, 32'h7F8, 1'b0, '0, LINE_EE, 2);

    do_reset();
    both_held();
    tick(2);

    // Reset during the WAIT phase of an I$ read: the access and response must never appear.
    t0 = cyc;
    icache_req_addr  = 32'h100;
    icache_req_valid = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    icache_req_valid = 1'b0;
    @(negedge clk);
    check_all_zero("post_midreset");
    tick(5);
    single(1'b0, 32'h400, 1'b0, '0, LINE_96, 0);

    for (int i = 0; i < 50 && (rsp_q.size() != 0 || mem_q.size() != 0); i++) tick(1);
    while (mem_q.size() != 0) begin
      mem_t m;
      m = mem_q.pop_front();
      fail("mem_missing", $sformatf("no access seen, required one at cycle %0d", m.cyc));
    end
    while (rsp_q.size() != 0) begin
      rsp_t r;
      r = rsp_q.pop_front();
      fail("rsp_missing", $sformatf("no response seen, required one at cycle %0d", r.cyc));
    end
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
